// File: rtl/c_lock_arbiter_chk.sv
// Registered round-robin arbiter that locks a grant across multi-flit packets,
// with a sticky checker for multi-hot grants and hold-protocol violations.
module c_lock_arbiter_chk #(
    parameter int num_ports    = 5,
    parameter bit enable_check = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic [num_ports-1:0] req,
    input  logic [num_ports-1:0] hold,
    output logic [num_ports-1:0] gnt,
    output logic                 gnt_valid,
    output logic                 error,
    output logic [1:0]           error_code
);
    localparam int PW = (num_ports > 1) ? $clog2(num_ports) : 1;

    typedef enum logic [1:0] {IDLE, GRANTED, LOCKED} state_t;

    state_t               state, state_nxt;
    logic [num_ports-1:0] gnt_q, gnt_nxt;
    logic [PW-1:0]        ptr, ptr_nxt;

    // Round-robin pick: requests at or above ptr win first, else wrap to the lowest.
    logic [num_ports-1:0] hi_mask, req_hi, pool, win;
    logic [PW-1:0]        win_idx, win_ptr;
    logic [PW-1:0]        enc [num_ports+1];
    logic                 keep;

    assign hi_mask = ~((num_ports'(1) << ptr) - num_ports'(1));
    assign req_hi  = req & hi_mask;
    assign pool    = (|req_hi) ? req_hi : req;
    assign win     = pool & (~pool + num_ports'(1));

    assign enc[0] = '0;
    for (genvar i = 0; i < num_ports; i++) begin : g_enc
        assign enc[i+1] = enc[i] | (win[i] ? PW'(i) : '0);
    end
    assign win_idx = enc[num_ports];
    assign win_ptr = (win_idx == PW'(num_ports - 1)) ? '0 : win_idx + PW'(1);

    // The current holder keeps the port only while it both requests and holds.
    assign keep = (state != IDLE) && (|(gnt_q & req & hold));

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        ptr_nxt   = ptr;
        if (active) begin
            if (keep) begin
                state_nxt = LOCKED;
            end else if (|req) begin
                state_nxt = GRANTED;
                gnt_nxt   = win;
                ptr_nxt   = win_ptr;
            end else begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt_q <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            gnt_q <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;

    if (enable_check) begin : g_chk
        logic [1:0] code;
        logic       multi_hot, hold_bad;

        assign multi_hot = |(gnt_q & (gnt_q - num_ports'(1)));
        assign hold_bad  = |(hold & ~gnt_q);

        // Checker runs regardless of active so a stalled pipeline is still watched.
        always_ff @(posedge clk) begin
            if (reset) code <= 2'b00;
            else       code <= code | {hold_bad, multi_hot};
        end
        assign error_code = code;
    end else begin : g_nochk
        assign error_code = 2'b00;
    end

    assign error = |error_code;
endmodule

// File: tb/tb_c_lock_arbiter_chk.sv
// Randomized and directed bench for c_lock_arbiter_chk against a holder/pointer
// reference model kept as plain integers.
module tb_c_lock_arbiter_chk;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset, active;
    logic [N-1:0] req, hold, gnt;
    logic         gnt_valid, error;
    logic [1:0]   error_code;

    int         m_g;    // current holder, -1 = none
    int         m_ptr;
    logic [1:0] m_err;
    int         n_chk = 0;
    int         n_fail = 0;

    c_lock_arbiter_chk #(.num_ports(N), .enable_check(1'b1)) dut (
        .clk(clk), .reset(reset), .active(active), .req(req), .hold(hold),
        .gnt(gnt), .gnt_valid(gnt_valid), .error(error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(input int p);
        logic [N-1:0] v;
        v = '0;
        if (p >= 0) v = N'(1) << p;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int w;
        if (reset) begin
            m_g = -1; m_ptr = 0; m_err = 2'b00;
            return;
        end
        for (int i = 0; i < N; i++)
            if (hold[i] && i != m_g) m_err[1] = 1'b1;
        if (!active) return;
        if (m_g >= 0 && req[m_g] && hold[m_g]) return;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
            m_g = w; m_ptr = (w + 1) % N;
        end else begin
            m_g = -1;
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), 32'(oh(m_g)));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_g >= 0));
        chk("error_code", 32'(error_code), 32'(m_err));
        chk("error", 32'(error), 32'(|m_err));
        chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; hold = '0; active = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; active = 1'b1; req = '0; hold = '0;
        m_g = -1; m_ptr = 0; m_err = 2'b00;

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_err", 32'({error, error_code}), 32'd0);

        // All requesting, no hold: ports 0..4 in turn
        req = '1;
        for (int k = 0; k < N; k++) begin
            step();
            chk("rr_seq", 32'(gnt), 32'(oh(k)));
        end
        chk("rr_err", 32'(error), 32'd0);

        // Port 2 locks for 3 hold cycles plus tail, then port 3
        do_reset();
        req = 5'b00100;
        step();
        chk("lock_first", 32'(gnt), 32'(oh(2)));
        req = '1; hold = 5'b00100;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lock_keep", 32'(gnt), 32'(oh(2)));
        end
        hold = '0;
        step();
        chk("lock_next", 32'(gnt), 32'(oh(3)));

        // Sole requester port 4 re-wins; pointer wraps to 0
        do_reset();
        req = oh(4);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("solo4", 32'(gnt), 32'(oh(4)));
        end
        req = '1;
        step();
        chk("wrap0", 32'(gnt), 32'(oh(0)));

        // Sweep every req value from every pointer position
        for (int p = 0; p < N; p++) begin
            for (int r = 0; r < (1 << N); r++) begin
                do_reset();
                if (p > 0) begin
                    req = oh(p - 1);
                    step();
                end
                req = N'(r);
                step();
            end
        end

        // Hold from a non-holder sets the sticky hold-violation code
        do_reset();
        req = oh(0);
        step();
        hold = 5'b01000;
        step();
        chk("hv_code", 32'(error_code), 32'd2);
        chk("hv_err", 32'(error), 32'd1);
        hold = '0; req = '0;
        for (int k = 0; k < 3; k++) step();
        chk("hv_sticky", 32'(error_code), 32'd2);
        do_reset();
        chk("hv_clear", 32'(error_code), 32'd0);

        // Freeze during LOCKED, then reset
        req = oh(1);
        step();
        hold = oh(1);
        step();
        active = 1'b0; hold = '0; req = '1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("freeze", 32'(gnt), 32'(oh(1)));
        end
        do_reset();
        chk("frz_rst", 32'(gnt), 32'd0);
        req = '1;
        step();
        chk("frz_p0", 32'(gnt), 32'(oh(0)));

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            int r;
            reset  = ($urandom_range(0, 99) == 0);
            active = ($urandom_range(0, 9) != 0);
            req    = N'($urandom);
            r      = $urandom_range(0, 99);
            if (r < 60)      hold = req & oh(m_g);
            else if (r < 97) hold = '0;
            else             hold = N'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/c_lock_arbiter_chk.md
# c_lock_arbiter_chk

Registered round-robin arbiter with packet-level grant locking and a built-in multi-hot grant checker. It shares a single downstream resource (switch output port or shared buffer write port) among `num_ports` requesters, keeping a grant across multi-cycle transfers. It continuously verifies that the grant vector is never multi-hot and that requesters follow the hold protocol. It sits between the per-input request logic and the crossbar/output controller in the router.

## Interface
- `num_ports`, 5, number of requesters (>= 2)
- `enable_check`, 1, 1 = checker logic present; 0 = `error`/`error_code` tied to 0
- `clk`  input  1  clock
- `reset`  input  1  synchronous, active-high reset
- `active`  input  1  1 = state may update this cycle; 0 = all registers hold
- `req`  input  `num_ports`  request vector, bit i = requester i
- `hold`  input  `num_ports`  bit i = requester i keeps its grant next cycle (non-tail flit)
- `gnt`  output  `num_ports`  registered grant, one-hot or zero
- `gnt_valid`  output  1  OR-reduction of `gnt`
- `error`  output  1  sticky protocol/integrity error
- `error_code`  output  2  sticky cause bits: [0] = multi-hot `gnt`, [1] = hold violation

## Operation
- State: `gnt` register, priority pointer `ptr` (clogb(num_ports) bits, value 0..num_ports-1), `locked` flag, error registers.
- FSM, derived from `gnt`/`locked`:
  - IDLE (`gnt`=0)
  - GRANTED (`gnt` one-hot, `locked`=0)
  - LOCKED (`gnt` one-hot, `locked`=1)
- Per cycle with `active`=1, g = currently granted port:
  - LOCKED or GRANTED with `req[g]` & `hold[g]`: keep `gnt`; `locked` <= 1; `ptr` unchanged.
  - Otherwise (IDLE, or holder releasing): arbitrate over `req`. Winner = first set bit scanning `ptr`, `ptr`+1, ..., wrapping modulo `num_ports`.
    - Winner w: `gnt` <= onehot(w); `ptr` <= (w+1) mod `num_ports`; `locked` <= 0.
    - No request: `gnt` <= 0; `ptr` unchanged.
- A releasing holder may win again only if it is the sole requester, because `ptr` already points past it.
- `hold[i]` without `req[i]` is ignored for arbitration.
- Checker, evaluated on the registered `gnt` every cycle regardless of `active`:
  - `gnt` has more than one bit set: set `error_code[0]`.
  - `hold[i]`=1 while `gnt[i]`=0: set `error_code[1]`.
- `error` = OR of `error_code`. Both are sticky and cleared only by `reset`.

## Timing
- Reset values: `gnt`=0, `gnt_valid`=0, `ptr`=0 (port 0 highest priority), `locked`=0, `error`=0, `error_code`=0.
- Latency: `req` sampled at edge t produces `gnt` visible after edge t; one cycle request-to-grant.
- Minimum tenure is 1 cycle. A transfer of N flits holds `hold`=1 for the first N-1 cycles of the grant and releases on the tail.
- Simultaneous release and new requests: arbitration happens in the release cycle, giving back-to-back grants with no idle cycle.
- `active`=0: `gnt`, `ptr` and `locked` freeze; the checker stays live.
- Reset mid-LOCKED: the next cycle is IDLE with `ptr`=0; error flags are cleared.
- Error flags set one cycle after the offending condition is sampled.

## Test plan
- Reset, then `req`=5'b11111 with `hold`=0 for 5 cycles -> `gnt` sequence 10000, 01000, 00100, 00010, 00001 (port 0 first); `error`=0.
- `req`=5'b00100, with `hold[2]`=1 for 3 cycles then 0, and `req`=5'b11111 from cycle 1 -> `gnt`=00100 for 4 cycles, then 00010 (`ptr`=3).
- Single requester port 4 with `hold`=0 for 3 cycles -> `gnt`=00001 on every cycle; `ptr` wraps to 0.
- Exhaustive sweep of all 2^5 `req` values for each `ptr` value, `hold`=0 -> `gnt` matches a reference RR model; `gnt` is never multi-hot; `error`=0.
- Assert `hold[3]`=1 while `gnt`=10000 -> `error`=1 and `error_code`=2'b10 on the next cycle; both stay set until `reset`.
- During LOCKED, drop `active` for 2 cycles, then assert `reset` -> `gnt` is frozen while `active`=0; after `reset`, `gnt`=0, `ptr`=0, and the next `req`=5'b11111 grants port 0.
